imem_loader: RTL and testbench

Write-side companion to the instruction ROM: accepts a byte stream over a valid/ready handshake, packs bytes big-endian into 32-bit MIPS instruction words, and writes them into the 2048 x 32 instruction memory from word address 0 upward. It sits between a host or UART byte source and the instruction memory's write port. It lets a program be loaded at run time instead of only from `code.txt` at elaboration.

---
 rtl/imem_loader.sv | 96 +++++++++
 tb/tb_imem_loader.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: packs a valid/ready byte stream big-endian into 32-bit words and writes them to instruction memory.
module imem_loader #(
  parameter int ADDR_W    = 11,
  parameter int MAX_WORDS = 2048
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  localparam logic [ADDR_W:0] MAX = MAX_WORDS[ADDR_W:0];
  state_t state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [31:0] pack_q, pack_d, wdata_q, wdata_d, word;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic we_q, we_d, err_q, err_d;
  logic acc, fin;
  // cnt_q doubles as the write pointer: every written word advances both together
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    pack_d = pack_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    we_d = 1'b0;
    err_d = err_q;
    acc = state_q == LOAD && byte_valid;
    word = pack_q | ({24'd0, byte_in} << (5'd24 - {idx_q, 3'b000}));
    fin = acc && (idx_q == 2'd3 || byte_last);
    if (state_q != LOAD && start) begin
      state_d = LOAD;
      idx_d = 2'd0;
      pack_d = 32'd0;
      cnt_d = '0;
      err_d = 1'b0;
    end
    if (acc) begin
      idx_d = idx_q + 2'd1;
      pack_d = word;
    end
    if (fin) begin
      idx_d = 2'd0;
      pack_d = 32'd0;
      if (cnt_q == MAX) err_d = 1'b1;
      else begin
        we_d = 1'b1;
        addr_d = cnt_q[ADDR_W-1:0];
        wdata_d = word;
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (acc && byte_last) state_d = DONE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= 2'd0;
      pack_q <= 32'd0;
      cnt_q <= '0;
      addr_q <= '0;
      wdata_q <= 32'd0;
      we_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      pack_q <= pack_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      we_q <= we_d;
      err_q <= err_d;
    end
  end
  assign byte_ready = state_q == LOAD;
  assign busy = state_q == LOAD;
  assign done = state_q == DONE;
  assign mem_we = we_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign error = err_q;
  assign word_count = cnt_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of packing, padding, stalls, overflow, restart and async reset.
module tb_imem_loader;
  logic clk = 1'b0;
  logic reset, start, byte_valid, byte_last;
  logic [7:0] byte_in;
  logic byte_ready, mem_we, busy, done, error;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [11:0] word_count;
  int checks = 0;
  int errors = 0;
  logic [31:0] la[$];
  logic [31:0] ld[$];
  imem_loader #(.ADDR_W(11), .MAX_WORDS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid),
    .byte_in(byte_in), .byte_last(byte_last), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error), .word_count(word_count)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (mem_we) begin
    la.push_back({21'd0, mem_addr});
    ld.push_back(mem_wdata);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic send(input logic [7:0] b, input logic l);
    byte_valid = 1'b1;
    byte_in = b;
    byte_last = l;
    tick();
    byte_valid = 1'b0;
    byte_last = 1'b0;
  endtask
  task automatic clr();
    la.delete();
    ld.delete();
  endtask
  task automatic chk_log(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
    chk({tag, "_addr"}, (la.size() > idx) ? la[idx] : 32'hxxxx_xxxx, a);
    chk({tag, "_data"}, (ld.size() > idx) ? ld[idx] : 32'hxxxx_xxxx, d);
  endtask
  initial begin
    logic [7:0] basic [8];
    basic = '{8'h3C, 8'h08, 8'h12, 8'h34, 8'h8C, 8'h09, 8'h00, 8'h04};
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_last = 1'b0; byte_in = 8'h00;
    #2;
    chk("rst_outs", {byte_ready, mem_we, busy, done, error}, 0);
    chk("rst_addr", {21'd0, mem_addr}, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_count", {20'd0, word_count}, 0);
    #5 reset = 1'b0;
    tick();
    // bytes offered before any start must be ignored
    byte_valid = 1'b1; byte_in = 8'hEE;
    tick(); tick();
    chk("pre_ready", {31'd0, byte_ready}, 0);
    chk("pre_busy", {31'd0, busy}, 0);
    byte_valid = 1'b0;
    tick();
    chk("pre_nwrites", la.size(), 0);
    // basic load
    do_start();
    chk("start_busy", {30'd0, busy, byte_ready}, 32'h3);
    for (int i = 0; i < 8; i++) begin
      send(basic[i], i == 7);
      if (i == 3) chk("b_we1", {31'd0, mem_we}, 1);
      if (i == 4) chk("b_we1_pulse", {31'd0, mem_we}, 0);
    end
    chk("b_final", {27'd0, mem_we, done, byte_ready, busy, error}, 32'b11000);
    chk("b_count", {20'd0, word_count}, 2);
    tick();
    chk("b_we_drop", {31'd0, mem_we}, 0);
    chk("b_nwrites", la.size(), 2);
    chk_log("b_w0", 0, 0, 32'h3C081234);
    chk_log("b_w1", 1, 1, 32'h8C090004);
    // padding of a short final word
    clr();
    do_start();
    chk("p_start_count", {20'd0, word_count}, 0);
    for (int i = 1; i <= 6; i++) send(8'(i * 8'h11), i == 6);
    chk("p_done_we", {30'd0, mem_we, done}, 32'h3);
    tick();
    chk("p_nwrites", la.size(), 2);
    chk_log("p_w0", 0, 0, 32'h11223344);
    chk_log("p_w1", 1, 1, 32'h55660000);
    // stalled stream; the byte presented with start must not be taken
    clr();
    byte_valid = 1'b1; byte_in = 8'hEE; start = 1'b1;
    tick();
    start = 1'b0; byte_valid = 1'b0;
    send(8'hAA, 1'b0); tick();
    send(8'hBB, 1'b0); tick(); tick();
    send(8'hCC, 1'b0);
    send(8'hDD, 1'b1);
    chk("s_done", {30'd0, mem_we, done}, 32'h3);
    tick(); tick();
    chk("s_nwrites", la.size(), 1);
    chk_log("s_w0", 0, 0, 32'hAABBCCDD);
    // overflow with a 4-word limit
    clr();
    do_start();
    for (int i = 1; i <= 20; i++) begin
      send(8'(i), i == 20);
      if (i == 19) chk("o_not_done", {31'd0, done}, 0);
    end
    chk("o_done", {31'd0, done}, 1);
    chk("o_we", {31'd0, mem_we}, 0);
    chk("o_error", {31'd0, error}, 1);
    chk("o_count", {20'd0, word_count}, 4);
    tick();
    chk("o_nwrites", la.size(), 4);
    chk_log("o_w0", 0, 0, 32'h01020304);
    chk_log("o_w1", 1, 1, 32'h05060708);
    chk_log("o_w2", 2, 2, 32'h090A0B0C);
    chk_log("o_w3", 3, 3, 32'h0D0E0F10);
    // restart clears error and count
    clr();
    do_start();
    chk("r_clear", {20'd0, word_count} | {31'd0, error}, 0);
    for (int i = 0; i < 4; i++) send(8'h00, i == 3);
    chk("r_we", {31'd0, mem_we}, 1);
    chk("r_count", {20'd0, word_count}, 1);
    tick();
    chk("r_nwrites", la.size(), 1);
    chk_log("r_w0", 0, 0, 32'h00000000);
    // asynchronous reset while a write strobe is live
    clr();
    do_start();
    for (int i = 0; i < 4; i++) send(8'(8'hA0 + i), 1'b0);
    chk("m_we_before", {31'd0, mem_we}, 1);
    #2 reset = 1'b1;
    #1;
    chk("m_we_async", {31'd0, mem_we}, 0);
    chk("m_idle", {29'd0, busy, done, byte_ready}, 0);
    tick();
    reset = 1'b0;
    tick();
    clr();
    do_start();
    send(8'hDE, 1'b0); send(8'hAD, 1'b0); send(8'hBE, 1'b0); send(8'hEF, 1'b1);
    chk("m_count", {20'd0, word_count}, 1);
    tick();
    chk("m_nwrites", la.size(), 1);
    chk_log("m_w0", 0, 0, 32'hDEADBEEF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
